jsv_frame_sequencer: RTL

Frame-level render sequencer for the Julia set pipeline. Scans the pixel grid in raster order, issues one coordinate per pixel to the iteration core over a valid/ready handshake, and tracks outstanding results. Publishes a 3-bit status code, which drives the `in_port` of the software-readable state PIO that the Nios polls. Also maintains a completed-frame counter.

---
 rtl/jsv_frame_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/jsv_frame_sequencer.sv
// jsv_frame_sequencer: raster-order coordinate issuer for the Julia iteration core with inflight tracking
// Ports: clk/reset_n (async active-low), start/abort pulses, coord_valid/coord_ready/coord_x/coord_y
// handshake to the iteration core, result_valid completion pulses, state (PIO status), frame_count.
// Option: define JSV_SEQ_AUTORESTART_EN to restart the next frame automatically one cycle after DONE.
module jsv_frame_sequencer #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  output logic                       coord_valid,
  input  logic                       coord_ready,
  output logic [$clog2(H_RES)-1:0]   coord_x,
  output logic [$clog2(V_RES)-1:0]   coord_y,
  input  logic                       result_valid,
  output logic [2:0]                 state,
  output logic [15:0]                frame_count
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic [IW-1:0] I_MAX  = IW'(MAX_INFLIGHT);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;
  state_t          r_state;
  logic            r_valid;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [IW-1:0]   r_inflight;
  logic [15:0]     r_frames;
  logic            w_hs;
  logic            w_dec;
  logic [IW-1:0]   w_inflight_nxt;
  logic            w_room;
  assign w_hs           = r_valid & coord_ready;
  // a result with nothing outstanding is dropped so the count never underflows
  assign w_dec          = result_valid & (r_inflight != '0);
  assign w_inflight_nxt = r_inflight + IW'(w_hs) - IW'(w_dec);
  // next-cycle valid looks at the count that will be registered, so valid never sits at the limit
  assign w_room         = w_inflight_nxt < I_MAX;
  assign coord_valid    = r_valid;
  assign coord_x        = r_x;
  assign coord_y        = r_y;
  assign state          = r_state;
  assign frame_count    = r_frames;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_inflight <= '0;
      r_frames   <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ISSUE;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= w_room;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            r_state <= S_ABORT;
            r_valid <= 1'b0;
          end else begin
            r_valid <= w_room;
            if (w_hs) begin
              if (r_x == X_LAST) begin
                r_x <= '0;
                if (r_y == Y_LAST) begin
                  r_state <= S_DRAIN;
                  r_y     <= '0;
                  r_valid <= 1'b0;
                end else begin
                  r_y <= r_y + 1'b1;
                end
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state <= S_ABORT;
          end else if (r_inflight == '0) begin
            r_state  <= S_DONE;
            r_frames <= r_frames + 16'd1;
          end
        end
        S_DONE: begin
`ifdef JSV_SEQ_AUTORESTART_EN
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ISSUE;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= w_room;
          end
`else
          if (abort) begin
            r_state <= S_IDLE;
          end else if (start) begin
            r_state <= S_ISSUE;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= w_room;
          end
`endif
        end
        S_ABORT: begin
          r_valid <= 1'b0;
          if (r_inflight == '0) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
